// File: rtl/cp0_exception_sequencer_if.sv
// -----------------------------------------------------------------------------
// cp0_exception_sequencer_if
//
// Bundles the pipeline-facing signals of the CP0 exception sequencer.
//   master : pipeline side (drives cause/ID/mtc0 info, receives redirect/mfc0)
//   slave  : sequencer side
//
// Signals
//   interruptSignal   [2:0]  external interrupt levels, synchronous to clk
//   overflow/undefined/outOfMemory  synchronous exception causes from ID
//   id_pc             [31:0] address of the instruction in ID
//   id_valid, id_stall       ID occupancy / load-use stall
//   eret                     ID holds an eret
//   cp_wr_en, cp_addr, cp_wr_data   mtc0 access
//   cp_rd_data        [31:0] mfc0 read data (combinational from cp_addr)
//   epc_ctrl, jumpAddressExcept, exceptClear   redirect to IF via ID
//   in_handler               sequencer is inside a handler
// -----------------------------------------------------------------------------
interface cp0_exception_sequencer_if;
  logic [2:0]  interruptSignal;
  logic        overflow;
  logic        undefined;
  logic        outOfMemory;
  logic [31:0] id_pc;
  logic        id_valid;
  logic        id_stall;
  logic        eret;
  logic        cp_wr_en;
  logic [4:0]  cp_addr;
  logic [31:0] cp_wr_data;
  logic [31:0] cp_rd_data;
  logic        epc_ctrl;
  logic [31:0] jumpAddressExcept;
  logic        exceptClear;
  logic        in_handler;

  modport master (
    output interruptSignal, overflow, undefined, outOfMemory,
    output id_pc, id_valid, id_stall, eret,
    output cp_wr_en, cp_addr, cp_wr_data,
    input  cp_rd_data, epc_ctrl, jumpAddressExcept, exceptClear, in_handler
  );

  modport slave (
    input  interruptSignal, overflow, undefined, outOfMemory,
    input  id_pc, id_valid, id_stall, eret,
    input  cp_wr_en, cp_addr, cp_wr_data,
    output cp_rd_data, epc_ctrl, jumpAddressExcept, exceptClear, in_handler
  );
endinterface

// File: rtl/cp0_exception_sequencer.sv
// -----------------------------------------------------------------------------
// cp0_exception_sequencer
//
// Sequences exception/interrupt entry and eret return for the 5-stage
// pipeline. Owns CP0 Status (12), Cause (13) and EPC (14), arbitrates the
// synchronous causes against three edge-latched interrupt lines, drives the
// one-cycle flush/redirect, and serves mfc0/mtc0 decoded in ID.
//
// Ports
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   cp0  : cp0_exception_sequencer_if.slave (see interface header)
//
// Redirects are decoded from the state register, so a request sampled in
// cycle N shows its redirect in cycle N+1, and reset forces every output low
// in the following cycle.
// -----------------------------------------------------------------------------
module cp0_exception_sequencer #(
  parameter logic [31:0] VECTOR_ADDR = 32'h0000_0008,
  parameter int          NUM_IRQ     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  cp0_exception_sequencer_if.slave cp0
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_ENTER   = 2'd1;
  localparam logic [1:0] ST_HANDLER = 2'd2;
  localparam logic [1:0] ST_RETURN  = 2'd3;

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  localparam logic [2:0] CODE_OOM   = 3'd1;
  localparam logic [2:0] CODE_OVF   = 3'd2;
  localparam logic [2:0] CODE_UNDEF = 3'd3;
  localparam logic [2:0] CODE_IRQ0  = 3'd4;

  logic [1:0]         r_state;
  logic               r_ie;
  logic [NUM_IRQ-1:0] r_im;
  logic               r_exl;
  logic               r_saved_ie;   // Status bit5, hidden from mfc0
  logic [2:0]         r_code;
  logic [NUM_IRQ-1:0] r_ip;
  logic               r_df;
  logic [31:0]        r_epc;
  logic [NUM_IRQ-1:0] r_irq_prev;

  logic               w_accept;
  logic               w_sync;
  logic [NUM_IRQ-1:0] w_eligible;
  logic               w_take;
  logic [2:0]         w_code;
  logic [NUM_IRQ-1:0] w_irq_win;
  logic               w_irq_found;
  logic [NUM_IRQ-1:0] w_ip_rise;
  logic [NUM_IRQ-1:0] w_ip_clr;
  logic               w_mtc0;

  assign w_accept   = cp0.id_valid & ~cp0.id_stall;
  assign w_sync     = cp0.outOfMemory | cp0.overflow | cp0.undefined;
  assign w_eligible = {NUM_IRQ{r_ie}} & r_im & r_ip;
  assign w_take     = (r_state == ST_RUN) & w_accept & (w_sync | (|w_eligible));

  // A take flushes the instruction in ID, so a coincident mtc0 never retires.
  assign w_mtc0     = cp0.cp_wr_en & w_accept & ~w_take;

  assign w_ip_rise  = cp0.interruptSignal & ~r_irq_prev;

  // Winner selection: synchronous causes first, then lowest irq index.
  // NOTE: every variable written in always_comb gets a default first; a
  // path that leaves one unassigned would infer a latch.
  always_comb begin
    w_code      = 3'd0;
    w_irq_win   = '0;
    w_irq_found = 1'b0;
    if (cp0.outOfMemory) begin
      w_code = CODE_OOM;
    end else if (cp0.overflow) begin
      w_code = CODE_OVF;
    end else if (cp0.undefined) begin
      w_code = CODE_UNDEF;
    end else begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (!w_irq_found && w_eligible[i]) begin
          w_irq_found  = 1'b1;
          w_irq_win[i] = 1'b1;
          w_code       = CODE_IRQ0 + 3'(i);
        end
      end
    end
  end

  // Pending bits clear when taken or by write-1-to-clear; a new edge in the
  // same cycle still wins because the set term is OR'ed in last.
  assign w_ip_clr = (w_take ? w_irq_win : '0)
                  | ((w_mtc0 && cp0.cp_addr == REG_CAUSE) ?
                     cp0.cp_wr_data[8 +: NUM_IRQ] : '0);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values and later assignments in this block
  // simply take priority over earlier ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_ie       <= 1'b0;
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_saved_ie <= 1'b0;
      r_code     <= 3'd0;
      r_ip       <= '0;
      r_df       <= 1'b0;
      r_epc      <= 32'd0;
      r_irq_prev <= '0;
    end else begin
      r_irq_prev <= cp0.interruptSignal;
      r_ip       <= (r_ip & ~w_ip_clr) | w_ip_rise;

      if (w_mtc0 && cp0.cp_addr == REG_STATUS) begin
        r_ie <= cp0.cp_wr_data[0];
        r_im <= cp0.cp_wr_data[1 +: NUM_IRQ];
      end
      if (w_mtc0 && cp0.cp_addr == REG_EPC) begin
        r_epc <= cp0.cp_wr_data;
      end

      // FSM updates come after the mtc0 writes so they override them.
      case (r_state)
        ST_RUN: begin
          if (w_take) begin
            r_epc      <= cp0.id_pc;
            r_code     <= w_code;
            r_exl      <= 1'b1;
            r_ie       <= 1'b0;
            r_saved_ie <= r_ie;
            r_state    <= ST_ENTER;
          end
        end
        ST_ENTER: begin
          r_state <= ST_HANDLER;
        end
        ST_HANDLER: begin
          // A fault inside the handler is only recorded; EPC is preserved.
          if (cp0.id_valid && w_sync) begin
            r_df <= 1'b1;
          end
          if (cp0.eret && w_accept) begin
            r_state <= ST_RETURN;
          end
        end
        ST_RETURN: begin
          r_ie    <= r_saved_ie;
          r_exl   <= 1'b0;
          r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign cp0.exceptClear       = (r_state == ST_ENTER) | (r_state == ST_RETURN);
  assign cp0.epc_ctrl          = (r_state == ST_ENTER);
  assign cp0.jumpAddressExcept = (r_state == ST_ENTER)  ? VECTOR_ADDR :
                                 (r_state == ST_RETURN) ? r_epc : 32'd0;
  assign cp0.in_handler        = (r_state == ST_HANDLER);

  always_comb begin
    cp0.cp_rd_data = 32'd0;
    case (cp0.cp_addr)
      REG_STATUS: cp0.cp_rd_data = {27'd0, r_exl, r_im, r_ie};
      REG_CAUSE:  cp0.cp_rd_data = {r_df, 20'd0, r_ip, 3'd0, r_code, 2'd0};
      REG_EPC:    cp0.cp_rd_data = r_epc;
      default:    cp0.cp_rd_data = 32'd0;
    endcase
  end

endmodule

// File: doc/cp0_exception_sequencer.md
Name: cp0_exception_sequencer

Overview:
- Sequences exception and interrupt entry and return for the 5-stage pipeline.
- Owns the CP0 Status, Cause and EPC registers and arbitrates between synchronous exception causes and three external interrupt lines.
- Drives the one-cycle flush/redirect that the ID stage forwards to the IF stage, and serves mfc0/mtc0 accesses decoded in ID.

Parameters:
- VECTOR_ADDR, 32'h0000_0008, handler entry address driven on exception/interrupt entry.
- NUM_IRQ, 3, number of external interrupt lines; fixed at 3 in this revision.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- interruptSignal  input  3  external interrupt lines, level, already synchronous to clk.
- overflow  input  1  ALU overflow on the instruction currently in ID.
- undefined  input  1  undefined opcode in ID.
- outOfMemory  input  1  address-out-of-range in ID.
- id_pc  input  32  address of the instruction in ID (the return address).
- id_valid  input  1  ID holds a real, non-bubble instruction.
- id_stall  input  1  ID is stalled this cycle (load-use).
- eret  input  1  ID holds an eret instruction.
- cp_wr_en  input  1  mtc0 in ID.
- cp_addr  input  5  CP0 register number for mfc0/mtc0.
- cp_wr_data  input  32  mtc0 data (forwarded Rt).
- cp_rd_data  output  32  mfc0 data, combinational from cp_addr.
- epc_ctrl  output  1  high during an entry redirect.
- jumpAddressExcept  output  32  redirect target.
- exceptClear  output  1  flush IF/ID and squash ID for one cycle.
- in_handler  output  1  FSM is in HANDLER.

Behaviour:

Registers:
- Status (reg 12): bit0 IE; bits[3:1] IM[2:0]; bit4 EXL; other bits read as 0.
- Cause (reg 13): bits[4:2] code; bits[10:8] IP[2:0] pending; bit31 DF, a sticky double-fault flag.
- EPC (reg 14): 32 bits.
- mfc0 of any other cp_addr returns 0.

Exception codes:
- outOfMemory = 3'd1, overflow = 3'd2, undefined = 3'd3.
- irq0 = 3'd4, irq1 = 3'd5, irq2 = 3'd6.

Pending latch:
- IP[i] is set on a rising edge of interruptSignal[i] (the previous sample is held in a register).
- IP[i] is cleared when irq i is taken, or by an mtc0 to Cause with data bit (8+i) = 1 (write-1-to-clear).
- A set and a clear in the same cycle: set wins.

Priority:
- outOfMemory > overflow > undefined > irq0 > irq1 > irq2.
- An irq is eligible only if IE & IM[i] & IP[i].
- "take" = id_valid & !id_stall & (any sync cause or any eligible irq).

FSM states: RUN, ENTER, HANDLER, RETURN.
- RUN, on take:
  - EPC <= id_pc; code <= winner; clear the winning IP bit.
  - EXL <= 1; IE <= 0 (the pre-entry IE is saved in Status bit5, which reads as 0 via mfc0).
  - Next state ENTER.
- RUN, no take, or a request arriving while id_stall = 1: stay in RUN. The request is retried each cycle and is not lost.
- ENTER: exactly one cycle.
  - exceptClear = 1, epc_ctrl = 1, jumpAddressExcept = VECTOR_ADDR.
  - Next state HANDLER.
- HANDLER:
  - Interrupts are not taken.
  - A sync cause with id_valid sets DF and is otherwise ignored; EPC is not overwritten.
  - On eret & id_valid & !id_stall: go to RETURN.
- RETURN: exactly one cycle.
  - exceptClear = 1, epc_ctrl = 0, jumpAddressExcept = EPC.
  - IE <= saved IE; EXL <= 0.
  - Next state RUN. The earliest new take is in the cycle after RETURN.
- eret seen in RUN is ignored (no redirect).

Output defaults (outside ENTER/RETURN):
- exceptClear = 0, epc_ctrl = 0, jumpAddressExcept = 0.
- in_handler = 1 only in HANDLER.

mtc0 writes:
- Accepted when cp_wr_en & id_valid & !id_stall, in any state.
- Status bits[3:0] and EPC are writable; Cause accepts only the IP write-1-to-clear.
- If an mtc0 coincides with a take in RUN, the take's register updates win, and the mtc0 instruction itself is squashed by the flush.

Reset:
- Applies on any cycle, including mid-ENTER or mid-RETURN.
- Next state RUN; Status, Cause, EPC and the edge-detect history all go to 0.
- All outputs 0 in the cycle after reset is sampled.

Latency:
- Request sampled in cycle N → redirect visible in cycle N+1.
- eret sampled in cycle M → return redirect visible in cycle M+1.

Test Plan:
1. Reset, then overflow=1 with id_valid=1, id_pc=32'h40 → next cycle exceptClear=1, epc_ctrl=1, jumpAddressExcept=32'h8; EPC=32'h40; Cause[4:2]=2; in_handler=1 afterwards.
2. In HANDLER, eret with id_valid=1 → next cycle exceptClear=1, epc_ctrl=0, jumpAddressExcept=32'h40; then RUN with IE restored to its pre-entry value.
3. mtc0 Status=32'h3 (IE=1, IM0=1), then pulse interruptSignal[0] → IP0 set, interrupt taken at the first cycle with id_valid & !id_stall; code 4; IP0 cleared. Holding id_stall=1 for 3 cycles delays the take by exactly 3 cycles.
4. outOfMemory and an eligible irq1 in the same cycle → code 1 taken; IP1 stays set; irq1 is not taken in HANDLER and is taken after return (the cycle after RETURN at the earliest).
5. Undefined during HANDLER → DF=1, EPC unchanged, no redirect. mtc0 Cause with data 32'h100 clears IP0 only.
6. Assert rst during ENTER → next cycle exceptClear=0, Status=Cause=EPC=0, FSM in RUN. A pending interrupt edge from before reset is not taken.
